// File: rtl/aes_ahb_pkg.sv
// Shared types for the AES AHB slave: bus transfer encoding, decoder states,
// register offsets and the downstream interface state encoding.
package aes_ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      DEC_IDLE,
      DEC_WAIT_WK,
      DEC_WAIT_WD,
      DEC_ISSUE_WK,
      DEC_ISSUE_WD,
      DEC_ISSUE_RD,
      DEC_ISSUE_ERR,
      DEC_KEY_BUSY
   } dec_state_t;

   // Downstream AMBA/SRAM interface states; kept here so both sides agree.
   typedef enum logic [2:0] {
      AIF_IDLE,
      AIF_WRITE_KEY,
      AIF_WRITE_DATA,
      AIF_READ_DATA,
      AIF_RESP_ERR1,
      AIF_RESP_ERR2,
      AIF_KEY_BUSY
   } aif_state_t;

   localparam logic [7:0] KEY_OFF_DEF  = 8'h00;
   localparam logic [7:0] DATA_OFF_DEF = 8'h20;

   function automatic logic htrans_active(input htrans_t t);
      return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/hclk_edge_sync.sv
// Three-flop synchronizer for a slow clock sampled as data, with one-cycle
// rise/fall strobes. Strobes are held off until the pipeline holds real samples.
module hclk_edge_sync (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic       s1;
   logic       s2;
   logic       s3;
   logic [2:0] fill;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         fill <= 3'b000;
      end else begin
         s1   <= async_in;
         s2   <= s1;
         s3   <= s2;
         fill <= {fill[1:0], 1'b1};
      end
   end

   // Without the fill gate, a high input across reset release looks like a rise.
   assign rise = fill[2] &  s2 & ~s3;
   assign fall = fill[2] & ~s2 &  s3;

endmodule

// File: rtl/ahb_slave_decoder.sv
// AES AHB slave front end: samples HCLK in the clk domain and decodes each
// accepted transfer into one-cycle command pulses. Optional: DECODE_ERR_CNT_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a valid transfer on an HCLK rise with ready_in
// WAIT_WK    | key write accepted, waiting for data-phase HCLK fall
// WAIT_WD    | data write accepted, waiting for data-phase HCLK fall
// ISSUE_WK   | writek_enable pulse
// ISSUE_WD   | writed_enable pulse
// ISSUE_RD   | readd_enable pulse
// ISSUE_ERR  | hresp_error pulse
// KEY_BUSY   | hready_enable held for KEY_BUSY_CYC cycles
module ahb_slave_decoder
   import aes_ahb_pkg::*;
#(
   parameter int               DEC_W        = 8,
   parameter logic [DEC_W-1:0] KEY_OFF      = DEC_W'(KEY_OFF_DEF),
   parameter logic [DEC_W-1:0] DATA_OFF     = DEC_W'(DATA_OFF_DEF),
   parameter int               KEY_BUSY_CYC = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        HCLK,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [1:0]  HTRANS,
   input  logic        ready_in,
   output logic        HCLK_rise,
   output logic        HCLK_fall,
   output logic        writek_enable,
   output logic        writed_enable,
   output logic        readd_enable,
   output logic        hresp_error,
   output logic        hready_enable
`ifdef DECODE_ERR_CNT_EN
   ,
   input  logic        err_clr,
   output logic [7:0]  err_count
`endif
);

   localparam int                CNT_W     = (KEY_BUSY_CYC > 1) ? $clog2(KEY_BUSY_CYC) : 1;
   localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(KEY_BUSY_CYC - 1);

   dec_state_t       state;
   dec_state_t       state_nxt;
   logic             sh_sel;
   logic             sh_write;
   htrans_t          sh_trans;
   logic [DEC_W-1:0] sh_addr;
   logic [CNT_W-1:0] busy_cnt;
   logic             accept;

   hclk_edge_sync u_edge (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (HCLK),
      .rise     (HCLK_rise),
      .fall     (HCLK_fall)
   );

   // Capture mid-HCLK-cycle, where the address-phase signals are settled.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sh_sel   <= 1'b0;
         sh_write <= 1'b0;
         sh_trans <= HTRANS_IDLE;
         sh_addr  <= '0;
      end else if (HCLK_fall) begin
         sh_sel   <= HSEL;
         sh_write <= HWRITE;
         sh_trans <= htrans_t'(HTRANS);
         sh_addr  <= HADDR[DEC_W-1:0];
      end
   end

   generate
      if (DEC_W < 32) begin : g_addr_hi
         logic unused_haddr_hi;
         assign unused_haddr_hi = ^HADDR[31:DEC_W];
      end
   endgenerate

   assign accept = HCLK_rise && ready_in && (state == DEC_IDLE) &&
                   sh_sel && htrans_active(sh_trans);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= DEC_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DEC_IDLE: begin
            if (accept) begin
               if (sh_write && sh_addr == KEY_OFF)       state_nxt = DEC_WAIT_WK;
               else if (sh_write && sh_addr == DATA_OFF) state_nxt = DEC_WAIT_WD;
               else if (!sh_write && sh_addr == DATA_OFF) state_nxt = DEC_ISSUE_RD;
               else                                      state_nxt = DEC_ISSUE_ERR;
            end
         end
         DEC_WAIT_WK:   if (HCLK_fall) state_nxt = DEC_ISSUE_WK;
         DEC_WAIT_WD:   if (HCLK_fall) state_nxt = DEC_ISSUE_WD;
         DEC_ISSUE_WK:  state_nxt = DEC_KEY_BUSY;
         DEC_ISSUE_WD:  state_nxt = DEC_IDLE;
         DEC_ISSUE_RD:  state_nxt = DEC_IDLE;
         DEC_ISSUE_ERR: state_nxt = DEC_IDLE;
         DEC_KEY_BUSY:  if (busy_cnt == '0) state_nxt = DEC_IDLE;
         default:       state_nxt = DEC_IDLE;
      endcase
   end

   // Loaded while leaving ISSUE_WK so KEY_BUSY starts at the full count.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                                       busy_cnt <= '0;
      else if (state == DEC_ISSUE_WK)                   busy_cnt <= BUSY_LOAD;
      else if (state == DEC_KEY_BUSY && busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
   end

   assign writek_enable = (state == DEC_ISSUE_WK);
   assign writed_enable = (state == DEC_ISSUE_WD);
   assign readd_enable  = (state == DEC_ISSUE_RD);
   assign hresp_error   = (state == DEC_ISSUE_ERR);
   assign hready_enable = (state == DEC_KEY_BUSY);

`ifdef DECODE_ERR_CNT_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                                    err_count <= 8'h00;
      else if (err_clr)                              err_count <= 8'h00;
      else if (hresp_error && err_count != 8'hFF)    err_count <= err_count + 8'h01;
   end
`endif

   a_busy_cyc_legal: assert property (@(posedge clk) KEY_BUSY_CYC != 0)
      else $error("KEY_BUSY_CYC must be nonzero");

endmodule

// File: tb/tb_ahb_slave_decoder.sv
// Scoreboard bench for ahb_slave_decoder: HCLK is driven as data at 1/8 of clk,
// expected command pulses (type and clk cycle) are queued at each HCLK rise.
module tb_ahb_slave_decoder;

   localparam int CMD_NONE = 0;
   localparam int CMD_WK   = 1;
   localparam int CMD_WD   = 2;
   localparam int CMD_RD   = 3;
   localparam int CMD_ERR  = 4;

   typedef struct {
      int cmd;
      int cyc;
   } exp_t;

   logic        clk;
   logic        n_rst;
   logic        HCLK;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic        ready_in;
   logic        HCLK_rise;
   logic        HCLK_fall;
   logic        writek_enable;
   logic        writed_enable;
   logic        readd_enable;
   logic        hresp_error;
   logic        hready_enable;
`ifdef DECODE_ERR_CNT_EN
   logic        err_clr;
   logic [7:0]  err_count;
`endif

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   int   rise_cnt = 0;
   int   fall_cnt = 0;
   int   rise_w = 0;
   int   fall_w = 0;
   int   hr_run = 0;
   int   hr_runs = 0;

   ahb_slave_decoder dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .HCLK          (HCLK),
      .HSEL          (HSEL),
      .HADDR         (HADDR),
      .HWRITE        (HWRITE),
      .HTRANS        (HTRANS),
      .ready_in      (ready_in),
      .HCLK_rise     (HCLK_rise),
      .HCLK_fall     (HCLK_fall),
      .writek_enable (writek_enable),
      .writed_enable (writed_enable),
      .readd_enable  (readd_enable),
      .hresp_error   (hresp_error),
      .hready_enable (hready_enable)
`ifdef DECODE_ERR_CNT_EN
      ,
      .err_clr       (err_clr),
      .err_count     (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [6:0] all_outs();
      return {HCLK_rise, HCLK_fall, writek_enable, writed_enable,
              readd_enable, hresp_error, hready_enable};
   endfunction

   // Output monitor: pops the scoreboard on every command pulse.
   always @(negedge clk) begin
      int   code;
      exp_t e;
      if (!n_rst) begin
         rise_w = 0;
         fall_w = 0;
         hr_run = 0;
      end else begin
         code = writek_enable ? CMD_WK : writed_enable ? CMD_WD :
                readd_enable  ? CMD_RD : hresp_error   ? CMD_ERR : CMD_NONE;
         if (code != CMD_NONE) begin
            chk("cmd_onehot", 32'($countones({writek_enable, writed_enable,
                                             readd_enable, hresp_error})), 1);
            if (sb_q.size() == 0) begin
               chk("unexpected_cmd", code, CMD_NONE);
            end else begin
               e = sb_q.pop_front();
               chk("cmd_type", code, e.cmd);
               chk("cmd_cycle", cyc, e.cyc);
            end
         end
         if (HCLK_rise) begin
            if (rise_w == 0) rise_cnt++;
            rise_w++;
         end else if (rise_w != 0) begin
            chk("rise_width", rise_w, 1);
            rise_w = 0;
         end
         if (HCLK_fall) begin
            if (fall_w == 0) fall_cnt++;
            fall_w++;
         end else if (fall_w != 0) begin
            chk("fall_width", fall_w, 1);
            fall_w = 0;
         end
         if (hready_enable) begin
            hr_run++;
         end else if (hr_run != 0) begin
            chk("hready_len", hr_run, 16);
            hr_runs++;
            hr_run = 0;
         end
      end
   end

   task automatic hclk_set(input logic lvl);
      @(negedge clk);
      HCLK = lvl;
      repeat (3) @(negedge clk);
   endtask

   // One full HCLK cycle: address phase presented while HCLK is high, then
   // fall (capture) and rise (acceptance). Expected pulse queued at the rise.
   task automatic xfer(input logic sel, input logic wr, input logic [1:0] trans,
                       input logic [31:0] addr, input int cmd);
      exp_t e;
      HSEL   = sel;
      HWRITE = wr;
      HTRANS = trans;
      HADDR  = addr;
      hclk_set(1'b0);
      @(negedge clk);
      HCLK  = 1'b1;
      e.cmd = cmd;
      e.cyc = (cmd == CMD_WK || cmd == CMD_WD) ? cyc + 7 : cyc + 3;
      if (cmd != CMD_NONE) sb_q.push_back(e);
      repeat (3) @(negedge clk);
   endtask

   task automatic idle_bus(input int n);
      for (int i = 0; i < n; i++) xfer(1'b0, 1'b0, 2'b00, 32'h0, CMD_NONE);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst    = 1'b0;
      HCLK     = 1'b1;
      HSEL     = 1'b0;
      HADDR    = 32'h0;
      HWRITE   = 1'b0;
      HTRANS   = 2'b00;
      ready_in = 1'b1;
`ifdef DECODE_ERR_CNT_EN
      err_clr  = 1'b0;
`endif

      // 1: reset with HCLK high, no false rise after release
      repeat (3) @(negedge clk);
      chk("reset_outs", {25'h0, all_outs()}, 32'h0);
      n_rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("no_false_rise", rise_cnt, 0);
      chk("post_rst_outs", {25'h0, all_outs()}, 32'h0);
      hclk_set(1'b0);
      hclk_set(1'b1);
      chk("first_fall", fall_cnt, 1);
      chk("first_rise", rise_cnt, 1);

      // 2: data write
      xfer(1'b1, 1'b1, 2'b10, 32'h0000_0020, CMD_WD);
      idle_bus(2);

      // 3: key write, then a valid transfer during the busy window
      xfer(1'b1, 1'b1, 2'b10, 32'h0000_0000, CMD_WK);
      xfer(1'b1, 1'b0, 2'b10, 32'h0000_0020, CMD_NONE);
      idle_bus(3);
      chk("hready_runs", hr_runs, 1);

      // 4: read, key read error, unmapped write error, ignored transfers
      xfer(1'b1, 1'b0, 2'b11, 32'hABCD_0020, CMD_RD);
      xfer(1'b1, 1'b0, 2'b10, 32'h0000_0000, CMD_ERR);
      xfer(1'b1, 1'b1, 2'b10, 32'h0000_0044, CMD_ERR);
      xfer(1'b1, 1'b0, 2'b01, 32'h0000_0020, CMD_NONE);
      xfer(1'b0, 1'b1, 2'b10, 32'h0000_0020, CMD_NONE);
      idle_bus(1);
`ifdef DECODE_ERR_CNT_EN
      chk("err_count", {24'h0, err_count}, 32'd2);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_count_clr", {24'h0, err_count}, 32'd0);
`endif

      // 5: ready_in low across two rises, then one command
      ready_in = 1'b0;
      xfer(1'b1, 1'b0, 2'b10, 32'h0000_0020, CMD_NONE);
      xfer(1'b1, 1'b0, 2'b10, 32'h0000_0020, CMD_NONE);
      ready_in = 1'b1;
      xfer(1'b1, 1'b0, 2'b10, 32'h0000_0020, CMD_RD);
      idle_bus(2);

      // 6a: reset in WAIT_WD aborts the pending write
      xfer(1'b1, 1'b1, 2'b10, 32'h0000_0020, CMD_NONE);
      #2 n_rst = 1'b0;
      #1 chk("rst_wait_wd_outs", {25'h0, all_outs()}, 32'h0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (4) @(negedge clk);
      idle_bus(2);

      // 6b: reset in KEY_BUSY drops hready_enable at once
      xfer(1'b1, 1'b1, 2'b10, 32'h0000_0000, CMD_WK);
      idle_bus(1);
      chk("busy_before_rst", {31'h0, hready_enable}, 32'h1);
      #2 n_rst = 1'b0;
      #1 chk("rst_busy_outs", {25'h0, all_outs()}, 32'h0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (4) @(negedge clk);
      idle_bus(4);
      chk("hready_runs_end", hr_runs, 1);

      // recovery after reset: a normal write still works
      xfer(1'b1, 1'b1, 2'b10, 32'h0000_0020, CMD_WD);
      idle_bus(2);
      chk("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
